apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 157 +++++++++++++++
 tb/tb_apb_master.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// apb_master: single-outstanding command-to-APB requester with a wait-state timeout.
// Rev 1.0 - initial release.
`default_nettype none

module apb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_error,
  output logic                    rsp_timeout,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
      CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]            state_q,   state_d;
  logic                  write_q,   write_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic [STRB_WIDTH-1:0] strb_q,    strb_d;
  logic [CNT_WIDTH-1:0]  cnt_q,     cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic                  error_q,   error_d;
  logic                  timeout_q, timeout_d;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          // Reads carry zero data/strobes so the bus never shows stale write data.
          state_d = S_SETUP;
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_write ? cmd_wdata : '0;
          strb_d  = cmd_write ? cmd_strb : '0;
          cnt_d   = '0;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (PREADY) begin
          state_d   = S_RESP;
          rdata_d   = write_q ? '0 : PRDATA;
          error_d   = PSLVERR;
          timeout_d = 1'b0;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          state_d   = S_RESP;
          rdata_d   = '0;
          error_d   = 1'b1;
          timeout_d = 1'b1;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Every output is a decode of registered state, so no input reaches an output.
  always_comb begin
    cmd_ready   = (state_q == S_IDLE);
    PSEL        = 1'b0;
    PENABLE     = 1'b0;
    PWRITE      = 1'b0;
    PADDR       = '0;
    PWDATA      = '0;
    PSTRB       = '0;
    rsp_valid   = 1'b0;
    rsp_rdata   = '0;
    rsp_error   = 1'b0;
    rsp_timeout = 1'b0;
    case (state_q)
      S_SETUP, S_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = (state_q == S_ACCESS);
        PWRITE  = write_q;
        PADDR   = addr_q;
        PWDATA  = wdata_q;
        PSTRB   = strb_q;
      end
      S_RESP: begin
        rsp_valid   = 1'b1;
        rsp_rdata   = rdata_q;
        rsp_error   = error_q;
        rsp_timeout = timeout_q;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized scoreboard bench for apb_master with an APB completer model.
// Rev 1.0 - initial release.
`default_nettype none

module tb_apb_master;

  localparam int TO = 16;

  logic        PCLK;
  logic        PRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  apb_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_strb   (cmd_strb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .rsp_timeout(rsp_timeout),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PSTRB      (PSTRB),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic        perr;
    logic [31:0] prdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_acc;
    int          acc_cyc;
  } txn_t;

  txn_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rr_low_until = 0;
  bit   rand_rr = 0;
  bit   rsp_first = 1;

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (failures so far %0d)", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a transfer times out iff the completer stalls for TO or more cycles.
  function automatic txn_t model(input txn_t t);
    txn_t r;
    r = t;
    if (t.waits >= TO) begin
      r.exp_rdata = 32'h0;
      r.exp_err   = 1'b1;
      r.exp_to    = 1'b1;
      r.exp_acc   = TO;
    end else begin
      r.exp_rdata = t.write ? 32'h0 : t.prdata;
      r.exp_err   = t.perr;
      r.exp_to    = 1'b0;
      r.exp_acc   = t.waits + 1;
    end
    return r;
  endfunction

  function automatic txn_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input int wt, input logic e,
                              input logic [31:0] rd);
    txn_t t;
    t = '{default: '0};
    t.write  = w;
    t.addr   = a;
    t.wdata  = d;
    t.strb   = s;
    t.waits  = wt;
    t.perr   = e;
    t.prdata = rd;
    return t;
  endfunction

  task automatic do_cmd(input txn_t t_in);
    txn_t t;
    int   guard;
    t = model(t_in);
    cmd_valid = 1'b1;
    cmd_write = t.write;
    cmd_addr  = t.addr;
    cmd_wdata = t.wdata;
    cmd_strb  = t.strb;
    guard = 0;
    while (!cmd_ready && guard < 200) begin
      @(negedge PCLK);
      guard++;
    end
    chk("cmd_accept_bound", 32'(cmd_ready), 32'd1);
    if (cmd_ready) begin
      t.acc_cyc = cyc + 1;
      exp_q.push_back(t);
    end
    @(negedge PCLK);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_strb  = 4'($urandom);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge PCLK);
      guard++;
    end
    chk("drain_bound", exp_q.size(), 32'd0);
  endtask

  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(negedge PCLK);
      if (cyc < rr_low_until) rsp_ready = 1'b0;
      else if (rand_rr)       rsp_ready = ($urandom_range(0, 3) != 0);
      else                    rsp_ready = 1'b1;
    end
  end

  // APB completer: stalls exactly 'waits' ACCESS cycles, noise everywhere else.
  initial begin : completer
    int k;
    k = 0;
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = 32'h0;
    forever begin
      @(negedge PCLK);
      #1;
      if (!PRESET && PSEL && PENABLE && exp_q.size() > 0 && k == exp_q[0].waits) begin
        PREADY  = 1'b1;
        PSLVERR = exp_q[0].perr;
        PRDATA  = exp_q[0].prdata;
      end else begin
        PREADY  = (PSEL && PENABLE) ? 1'b0 : 1'($urandom);
        PSLVERR = 1'($urandom);
        PRDATA  = $urandom;
      end
      if (PRESET || !PSEL) k = 0;
      else if (PENABLE)    k++;
    end
  end

  initial begin : rsp_mon
    forever begin
      @(negedge PCLK);
      #1;
      if (PRESET) begin
        exp_q.delete();
        rsp_first = 1;
      end else if (rsp_valid) begin
        chk("rsp_expected", exp_q.size(), 32'd1);
        if (exp_q.size() > 0) begin
          chk("rsp_cmd_ready_low", 32'(cmd_ready), 32'd0);
          chk("rsp_rdata",   rsp_rdata,          exp_q[0].exp_rdata);
          chk("rsp_error",   32'(rsp_error),     32'(exp_q[0].exp_err));
          chk("rsp_timeout", 32'(rsp_timeout),   32'(exp_q[0].exp_to));
          if (rsp_first) begin
            chk("rsp_latency", cyc - exp_q[0].acc_cyc, 1 + exp_q[0].exp_acc);
            rsp_first = 0;
          end
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            rsp_first = 1;
          end
        end
      end
    end
  end

  initial begin : apb_mon
    txn_t cur;
    bit   have;
    bit   p_sel;
    bit   p_en;
    int   alen;
    have = 0; p_sel = 0; p_en = 0; alen = 0;
    cur = '{default: '0};
    forever begin
      @(negedge PCLK);
      #1;
      if (PRESET) begin
        have = 0; p_sel = 0; p_en = 0; alen = 0;
      end else begin
        if (PSEL) begin
          chk("apb_cmd_ready_low", 32'(cmd_ready), 32'd0);
          if (!PENABLE) begin
            chk("setup_single_cycle", 32'(p_sel & ~p_en), 32'd0);
            chk("setup_expected", exp_q.size(), 32'd1);
            have = (exp_q.size() > 0);
            if (have) cur = exp_q[0];
            alen = 0;
          end else begin
            chk("access_after_setup", 32'(p_sel), 32'd1);
            alen++;
          end
          if (have) begin
            chk("paddr",  PADDR,          cur.addr);
            chk("pwrite", 32'(PWRITE),    32'(cur.write));
            chk("pwdata", PWDATA,         cur.write ? cur.wdata : 32'h0);
            chk("pstrb",  32'(PSTRB),     cur.write ? 32'(cur.strb) : 32'h0);
          end
        end else begin
          chk("idle_apb_zero", 32'({PENABLE, PWRITE, |PADDR, |PWDATA, |PSTRB}), 32'd0);
          chk("setup_to_access", 32'(p_sel & ~p_en), 32'd0);
          if (p_sel && p_en && have) begin
            chk("access_len", alen, cur.exp_acc);
            have = 0;
          end
        end
        p_sel = PSEL;
        p_en  = PENABLE;
      end
    end
  end

  initial begin : main
    txn_t t;
    int   r;
    int   wt;
    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    cmd_strb  = 4'h0;
    repeat (3) @(negedge PCLK);
    #1;
    chk("reset_cmd_ready",   32'(cmd_ready),   32'd1);
    chk("reset_rsp_valid",   32'(rsp_valid),   32'd0);
    chk("reset_psel",        32'(PSEL),        32'd0);
    chk("reset_penable",     32'(PENABLE),     32'd0);
    chk("reset_rsp_fields",  32'({rsp_error, rsp_timeout, |rsp_rdata}), 32'd0);
    @(negedge PCLK);
    PRESET = 1'b0;

    do_cmd(mk(1'b1, 32'h08, 32'hA5A50F0F, 4'hF, 0, 1'b0, $urandom));
    do_cmd(mk(1'b0, 32'h04, $urandom, 4'hF, 3, 1'b0, 32'h12345678));
    do_cmd(mk(1'b1, 32'h40, $urandom, 4'h3, 0, 1'b1, $urandom));
    do_cmd(mk(1'b0, 32'h10, $urandom, 4'h5, 40, 1'b0, $urandom));
    do_cmd(mk(1'b0, 32'h14, $urandom, 4'h0, TO - 1, 1'b1, 32'hCAFEF00D));
    do_cmd(mk(1'b1, 32'h18, $urandom, 4'h9, TO, 1'b0, $urandom));
    drain();

    // Host stalls the response while a second command is already waiting.
    rr_low_until = cyc + 8;
    do_cmd(mk(1'b0, 32'h20, $urandom, 4'hF, 0, 1'b0, 32'h0BADBEEF));
    do_cmd(mk(1'b1, 32'h24, 32'h11223344, 4'hC, 1, 1'b0, $urandom));
    drain();

    do_cmd(mk(1'b0, 32'h30, $urandom, 4'hF, 10, 1'b0, $urandom));
    @(negedge PCLK);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    #1;
    chk("midrst_psel",      32'(PSEL),      32'd0);
    chk("midrst_penable",   32'(PENABLE),   32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_paddr",     PADDR,          32'h0);
    repeat (20) @(negedge PCLK);

    rand_rr = 1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge PCLK);
      r  = $urandom_range(0, 9);
      wt = (r < 7) ? $urandom_range(0, 3) : (r < 9 ? $urandom_range(TO - 3, TO + 1)
                                                   : $urandom_range(0, 8));
      t = mk(1'($urandom), $urandom, $urandom, 4'($urandom), wt, 1'($urandom), $urandom);
      do_cmd(t);
    end
    drain();
    rand_rr = 0;
    repeat (4) @(negedge PCLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
